button_debouncer: RTL and testbench

//  Conditions raw board push-buttons (KEY[n], asynchronous, bouncing) into clean, clk-synchronous levels.

---
 rtl/btn_pkg.sv | 15 +
 rtl/button_debouncer_channel.sv | 78 +++++++
 rtl/button_debouncer.sv | 53 +++++
 tb/tb_button_debouncer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and width helper for the push-button debouncer
package btn_pkg;

   localparam int   DEF_TICK_DIV       = 500;
   localparam int   DEF_DEBOUNCE_TICKS = 2000;
   localparam logic KEY_PRESSED_LEVEL  = 1'b0;

   // Counter width that never collapses to zero bits for tiny parameters.
   function automatic int clog2_safe(input int n);
      int w;
      w = (n <= 2) ? 1 : $clog2(n);
      return w;
   endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - one button: synchroniser, stability counter, accepted level, strobes
module debounce_channel
   import btn_pkg::*;
#(
   parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter logic PRESSED_LEVEL  = KEY_PRESSED_LEVEL
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic btn_raw,
   output logic btn_out,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int                DCNT_W    = clog2_safe(DEBOUNCE_TICKS + 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

   logic              s1_q, s1_d;
   logic              s2_q, s2_d;
   logic              stable_q, stable_d;
   logic              changed_q, changed_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q      <= ~PRESSED_LEVEL;
         s2_q      <= ~PRESSED_LEVEL;
         stable_q  <= ~PRESSED_LEVEL;
         changed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         dcnt_q    <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         stable_q  <= stable_d;
         changed_q <= changed_d;
         press_q   <= press_d;
         release_q <= release_d;
         dcnt_q    <= dcnt_d;
      end
   end

   // Any sample matching the accepted level restarts qualification from zero.
   always_comb begin
      s1_d      = btn_raw;
      s2_d      = s1_q;
      stable_d  = stable_q;
      dcnt_d    = dcnt_q;
      changed_d = 1'b0;
      if (s2_q == stable_q) begin
         dcnt_d = '0;
      end else if (tick) begin
         if (dcnt_q == DCNT_LAST) begin
            stable_d  = s2_q;
            dcnt_d    = '0;
            changed_d = 1'b1;
         end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
         end
      end
   end

   // Strobes trail the level change by one cycle; direction comes from the new level.
   always_comb begin
      press_d   = changed_q && (stable_q == PRESSED_LEVEL);
      release_d = changed_q && (stable_q != PRESSED_LEVEL);
   end

   assign btn_out       = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - shared tick prescaler feeding N independent debounce channels
module button_debouncer
   import btn_pkg::*;
#(
   parameter int   N_BUTTONS      = 4,
   parameter int   TICK_DIV       = DEF_TICK_DIV,
   parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter logic PRESSED_LEVEL  = KEY_PRESSED_LEVEL
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_out,
   output logic [N_BUTTONS-1:0] press_pulse,
   output logic [N_BUTTONS-1:0] release_pulse
);

   localparam int               CNT_W    = clog2_safe(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // With TICK_DIV = 1 the counter sits at zero and tick stays high.
   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .PRESSED_LEVEL  (PRESSED_LEVEL)
      ) u_chan (
         .clk           (clk),
         .reset_n       (reset_n),
         .tick          (tick),
         .btn_raw       (btn_raw[i]),
         .btn_out       (btn_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed and random checks of button_debouncer against a run-length model
module tb_button_debouncer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] raw_a = 4'h0;
   logic [0:0] raw_b = 1'b1;
   logic [3:0] out_a, press_a, rel_a;
   logic [0:0] out_b, press_b, rel_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_debouncer #(
      .N_BUTTONS(4), .TICK_DIV(1), .DEBOUNCE_TICKS(8), .PRESSED_LEVEL(1'b0)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .btn_raw(raw_a),
      .btn_out(out_a), .press_pulse(press_a), .release_pulse(rel_a)
   );

   button_debouncer #(
      .N_BUTTONS(1), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .PRESSED_LEVEL(1'b0)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .btn_raw(raw_b),
      .btn_out(out_b), .press_pulse(press_b), .release_pulse(rel_b)
   );

   // Reference: a level is accepted once the synchronised input has held one value
   // (different from the accepted level) across DEBOUNCE_TICKS tick cycles.
   int   m_td  [2] = '{1, 4};
   int   m_db  [2] = '{8, 3};
   int   m_nch [2] = '{4, 1};
   logic m_s1 [2][4];
   logic m_s2 [2][4];
   logic m_stable [2][4];
   logic m_changed [2][4];
   logic m_press [2][4];
   logic m_rel [2][4];
   logic m_runval [2][4];
   int   m_run [2][4];
   int   edge_n;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      edge_n = 0;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 4; c++) begin
            m_s1[k][c] = 1'b1;  m_s2[k][c] = 1'b1;  m_stable[k][c] = 1'b1;
            m_runval[k][c] = 1'b1;  m_run[k][c] = 0;
            m_changed[k][c] = 1'b0;  m_press[k][c] = 1'b0;  m_rel[k][c] = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      logic r, s2o;
      bit   tk;
      edge_n++;
      for (int k = 0; k < 2; k++) begin
         tk = ((edge_n % m_td[k]) == 0);
         for (int c = 0; c < m_nch[k]; c++) begin
            r = (k == 0) ? raw_a[c] : raw_b[0];
            m_press[k][c] = m_changed[k][c] && (m_stable[k][c] == 1'b0);
            m_rel[k][c]   = m_changed[k][c] && (m_stable[k][c] == 1'b1);
            s2o = m_s2[k][c];
            if (s2o == m_runval[k][c]) begin
               if (tk) m_run[k][c]++;
            end else begin
               m_runval[k][c] = s2o;
               m_run[k][c]    = tk ? 1 : 0;
            end
            m_changed[k][c] = 1'b0;
            if (s2o != m_stable[k][c] && m_run[k][c] == m_db[k]) begin
               m_stable[k][c]  = s2o;
               m_changed[k][c] = 1'b1;
            end
            m_s2[k][c] = m_s1[k][c];
            m_s1[k][c] = r;
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] ea, pa, ra;
      for (int c = 0; c < 4; c++) begin
         ea[c] = m_stable[0][c];  pa[c] = m_press[0][c];  ra[c] = m_rel[0][c];
      end
      check("a_btn_out", out_a, ea);
      check("a_press", press_a, pa);
      check("a_release", rel_a, ra);
      check("b_btn_out", out_b, m_stable[1][0]);
      check("b_press", press_b, m_press[1][0]);
      check("b_release", rel_b, m_rel[1][0]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_a"}, out_a, 4'hF);
      check({tag, "_press_a"}, press_a, 4'h0);
      check({tag, "_rel_a"}, rel_a, 4'h0);
      check({tag, "_out_b"}, out_b, 1'b1);
   endtask

   initial begin
      int fall, pe, rise, pcnt, rcnt;
      int fe [4];
      bit b_changed;
      int hold [5];

      // Reset with every button pressed, then full qualification from release.
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("t1_reset");
      reset_n = 1'b1;
      fall = 0; pe = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (fall == 0 && out_a[0] == 1'b0) fall = i;
         if (pe == 0 && press_a == 4'hF) pe = i;
      end
      check("t1_fall_edge", fall, 10);
      check("t1_press_edge", pe, 11);

      // Release of channel 2 after a qualified press.
      raw_a[2] = 1'b1;
      rise = 0; pcnt = 0; rcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (rise == 0 && out_a[2] == 1'b1) rise = i;
         if (press_a[2]) pcnt++;
         if (rel_a[2]) rcnt++;
      end
      check("t3_rise_edge", rise, 10);
      check("t3_release_count", rcnt, 1);
      check("t3_press_count", pcnt, 0);

      // Bouncing press on channel 1.
      raw_a[1] = 1'b1;
      repeat (20) step();
      fall = 0; pcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         raw_a[1] = (i <= 5) ? 1'b0 : (i <= 7) ? 1'b1 : 1'b0;
         step();
         if (fall == 0 && out_a[1] == 1'b0) fall = i;
         if (press_a[1]) pcnt++;
      end
      check("t2_fall_edge", fall, 17);
      check("t2_press_count", pcnt, 1);

      // Reset in the middle of a qualification.
      raw_a = 4'b1110;
      repeat (25) step();
      raw_a[3] = 1'b0;
      for (int i = 0; i < 20 && m_run[0][3] != 5; i++) step();
      check("t5_reached_dcnt5", m_run[0][3], 5);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values("t5_async_reset");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      fall = 0; pe = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (fall == 0 && out_a[3] == 1'b0) fall = i;
         if (pe == 0 && press_a[3]) pe = i;
      end
      check("t5_fall_edge", fall, 10);
      check("t5_press_edge", pe, 11);

      // All channels change together.
      raw_a = 4'hF;
      repeat (25) step();
      raw_a = 4'h0;
      for (int c = 0; c < 4; c++) fe[c] = 0;
      pe = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         for (int c = 0; c < 4; c++) if (fe[c] == 0 && out_a[c] == 1'b0) fe[c] = i;
         if (pe == 0 && press_a == 4'hF) pe = i;
      end
      for (int c = 0; c < 4; c++) check($sformatf("t6_fall_edge_%0d", c), fe[c], 10);
      check("t6_press_edge", pe, 11);

      // Prescaled instance: periodic 1-cycle glitches never qualify.
      b_changed = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         raw_b = ((i % 6) == 0) ? 1'b0 : 1'b1;
         step();
         if (out_b != 1'b1) b_changed = 1'b1;
      end
      check("t4_glitch_no_change", b_changed, 1'b0);
      raw_b = 1'b0;
      fall = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (fall == 0 && out_b == 1'b0) fall = i;
      end
      check("t4_latency_in_window", (fall >= 11 && fall <= 14), 1'b1);

      // Random hold lengths straddling the qualification threshold.
      for (int c = 0; c < 5; c++) hold[c] = 0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 5; c++) begin
            if (hold[c] == 0) begin
               if (c < 4) raw_a[c] = 1'($urandom_range(0, 1));
               else       raw_b    = 1'($urandom_range(0, 1));
               hold[c] = $urandom_range(1, 14);
            end
            hold[c]--;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
